// File: rtl/truth_table_checker.sv
// Self-timed checker: walks an external 3-input DUT through vectors 0..7,
// sampling each one after DWELL cycles and comparing f4/f5/f6 against truth tables.
module truth_table_checker #(
  parameter int unsigned DWELL  = 100,
  parameter logic [7:0]  EXP_F4 = 8'h96,
  parameter logic [7:0]  EXP_F5 = 8'hE8,
  parameter logic [7:0]  EXP_F6 = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       f4,
  input  logic       f5,
  input  logic       f6,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] mism,
  output logic       fail_valid,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  errCnt_q, errCnt_d;
  logic [2:0]  mism_q, mism_d;
  logic        failValid_q, failValid_d;
  logic [2:0]  failIdx_q, failIdx_d;

  logic        seqErr;
  logic [2:0]  mismNow;
  logic        badSample;
  logic [3:0]  errNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCnt_q    <= '0;
      mism_q      <= '0;
      failValid_q <= 1'b0;
      failIdx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      errCnt_q    <= errCnt_d;
      mism_q      <= mism_d;
      failValid_q <= failValid_d;
      failIdx_q   <= failIdx_d;
    end
  end

  // Sample evaluation is computed unconditionally; it only lands when cnt hits DWELL-1.
  always_comb begin
    seqErr    = ({x, y, z} != idx_q);
    mismNow   = {f4 ^ EXP_F4[idx_q], f5 ^ EXP_F5[idx_q], f6 ^ EXP_F6[idx_q]};
    badSample = seqErr || (mismNow != 3'b000);
    errNext   = errCnt_q + {3'b000, badSample};

    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    done_d      = done_q;
    pass_d      = pass_q;
    errCnt_d    = errCnt_q;
    mism_d      = mism_q;
    failValid_d = failValid_q;
    failIdx_d   = failIdx_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          cnt_d       = '0;
          idx_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          errCnt_d    = '0;
          mism_d      = '0;
          failValid_d = 1'b0;
          failIdx_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DWELL_LAST) begin
          mism_d   = mismNow;
          errCnt_d = errNext;
          if (badSample && !failValid_q) begin
            failValid_d = 1'b1;
            failIdx_d   = idx_q;
          end
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (errNext == 4'd0);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = errCnt_q;
  assign mism       = mism_q;
  assign fail_valid = failValid_q;
  assign fail_idx   = failIdx_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: clean, faulty, reset and DWELL=1 runs,
// with expected results worked out by hand from the logic functions.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start1;
  logic x, y, z, f4, f5, f6;

  logic       busy, done, pass, failValid;
  logic [3:0] errCnt;
  logic [2:0] mism, failIdx;

  logic       busy1, done1, pass1, failValid1;
  logic [3:0] errCnt1;
  logic [2:0] mism1, failIdx1;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .y(y), .z(z), .f4(f4), .f5(f5), .f6(f6),
    .busy(busy), .done(done), .pass(pass), .err_cnt(errCnt),
    .mism(mism), .fail_valid(failValid), .fail_idx(failIdx)
  );

  truth_table_checker #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x), .y(y), .z(z), .f4(f4), .f5(f5), .f6(f6),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(errCnt1),
    .mism(mism1), .fail_valid(failValid1), .fail_idx(failIdx1)
  );

  // Reference DUT: f4 = parity, f5 = majority, f6 = NOR of the three inputs.
  function automatic logic [2:0] expF(input int k);
    logic a, b, c;
    a = k[2]; b = k[1]; c = k[0];
    return {a ^ b ^ c, (a & b) | (a & c) | (b & c), ~(a | b | c)};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0 clean, 1 f6 stuck high at idx 3, 2 xyz held at 2 during idx 3,
  // 3 f4 inverted everywhere, 4 extra start pulse at cycle 5
  task automatic applyStimulus(input int mode);
    logic [2:0] fv;
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fv = expF(k);
      {x, y, z} = 3'(k);
      if (mode == 1 && k == 3) fv[0] = 1'b1;
      if (mode == 2 && k == 3) {x, y, z} = 3'd2;
      if (mode == 3) fv[2] = ~fv[2];
      {f4, f5, f6} = fv;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        n = k * 4 + c + 1;
        start = (mode == 4 && n == 5);
        if (n == 16 && mode == 1) checkOutput("f6FaultMism", 8'(mism), 8'h01);
        if (n == 16 && mode == 2) begin
          checkOutput("seqFaultMism", 8'(mism), 8'h00);
          checkOutput("seqFaultErrMid", 8'(errCnt), 8'h01);
        end
        if (n == 31) begin
          checkOutput("doneLowAt31", 8'(done), 8'h00);
          checkOutput("busyAt31", 8'(busy), 8'h01);
        end
      end
    end
    start = 1'b0;
    checkOutput("doneAt32", 8'(done), 8'h01);
    checkOutput("busyAt32", 8'(busy), 8'h00);
  endtask

  task automatic runDwell1(input bit fault);
    logic [2:0] fv;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fv = expF(k);
      if (fault && k == 5) fv[1] = ~fv[1];
      {x, y, z} = 3'(k);
      {f4, f5, f6} = fv;
      @(posedge clk); #1;
      if (k == 6) begin
        checkOutput("d1BusyAt7", 8'(busy1), 8'h01);
        checkOutput("d1DoneLowAt7", 8'(done1), 8'h00);
      end
    end
    checkOutput("d1DoneAt8", 8'(done1), 8'h01);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    {x, y, z, f4, f5, f6} = '0;
    #12;
    checkOutput("rstBusy", 8'(busy), 8'h00);
    checkOutput("rstDone", 8'(done), 8'h00);
    checkOutput("rstPass", 8'(pass), 8'h00);
    checkOutput("rstErr", 8'(errCnt), 8'h00);
    checkOutput("rstMism", 8'(mism), 8'h00);
    checkOutput("rstFailValid", 8'(failValid), 8'h00);
    checkOutput("rstFailIdx", 8'(failIdx), 8'h00);

    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleAfterRst", 8'(busy), 8'h00);

    applyStimulus(0);
    checkOutput("cleanPass", 8'(pass), 8'h01);
    checkOutput("cleanErr", 8'(errCnt), 8'h00);
    checkOutput("cleanFailValid", 8'(failValid), 8'h00);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("doneHolds", 8'(done), 8'h01);
    checkOutput("passHolds", 8'(pass), 8'h01);

    applyStimulus(1);
    checkOutput("f6FaultErr", 8'(errCnt), 8'h01);
    checkOutput("f6FaultIdx", 8'(failIdx), 8'h03);
    checkOutput("f6FaultValid", 8'(failValid), 8'h01);
    checkOutput("f6FaultPass", 8'(pass), 8'h00);

    applyStimulus(2);
    checkOutput("seqFaultErr", 8'(errCnt), 8'h01);
    checkOutput("seqFaultIdx", 8'(failIdx), 8'h03);
    checkOutput("seqFaultPass", 8'(pass), 8'h00);

    applyStimulus(3);
    checkOutput("allBadErr", 8'(errCnt), 8'h08);
    checkOutput("allBadIdx", 8'(failIdx), 8'h00);
    checkOutput("allBadPass", 8'(pass), 8'h00);
    checkOutput("allBadMism", 8'(mism), 8'h04);

    applyStimulus(4);
    checkOutput("restartIgnoredPass", 8'(pass), 8'h01);
    checkOutput("restartIgnoredErr", 8'(errCnt), 8'h00);

    // Mid-run reset during a run where every sample is wrong
    {x, y, z} = 3'd0;
    {f4, f5, f6} = 3'b111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("preRstErr", 8'(errCnt), 8'h02);
    checkOutput("preRstBusy", 8'(busy), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 8'(busy), 8'h00);
    checkOutput("asyncRstErr", 8'(errCnt), 8'h00);
    checkOutput("asyncRstMism", 8'(mism), 8'h00);
    checkOutput("asyncRstFailValid", 8'(failValid), 8'h00);
    checkOutput("asyncRstFailIdx", 8'(failIdx), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idleAfterMidRst", 8'(busy), 8'h00);
    applyStimulus(0);
    checkOutput("postRstPass", 8'(pass), 8'h01);
    checkOutput("postRstErr", 8'(errCnt), 8'h00);

    runDwell1(1'b0);
    checkOutput("d1CleanPass", 8'(pass1), 8'h01);
    checkOutput("d1CleanErr", 8'(errCnt1), 8'h00);
    runDwell1(1'b1);
    checkOutput("d1FaultErr", 8'(errCnt1), 8'h01);
    checkOutput("d1FaultIdx", 8'(failIdx1), 8'h05);
    checkOutput("d1FaultPass", 8'(pass1), 8'h00);
    checkOutput("dwell4Untouched", 8'(done), 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter DWELL, default 100, clock cycles each input vector is held; the legal range SHALL be 1..65535.
REQ-002 Parameter EXP_F4, default 8'h96, expected f4 truth table; bit i SHALL be the expected value for {x,y,z}==i.
REQ-003 Parameter EXP_F5, default 8'hE8, expected f5 truth table, using the same indexing.
REQ-004 Parameter EXP_F6, default 8'h01, expected f6 truth table, using the same indexing.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  one-cycle pulse that begins a check run.
REQ-008 x, y, z  input  1 each  applied input vector under observation; x is the MSB of the index.
REQ-009 f4, f5, f6  input  1 each  DUT outputs under observation.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from the end of a run until the next start or reset.
REQ-012 pass  output  1  valid while done is high; 1 means no error occurred.
REQ-013 err_cnt  output  4  number of sampled vectors with any error, range 0..8.
REQ-014 mism  output  3  {f4,f5,f6} mismatch bits of the most recent sample.
REQ-015 fail_valid  output  1  sticky flag; 1 once a first failure has been recorded.
REQ-016 fail_idx  output  3  expected index of the first failing vector.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE, with a 16-bit dwell counter cnt and a 3-bit vector index idx.
REQ-018 In IDLE or DONE, a start pulse SHALL, on that edge, enter RUN, clear cnt, idx, err_cnt, mism, fail_valid and fail_idx, and drop done and pass.
REQ-019 In RUN, start SHALL be ignored.
REQ-020 In RUN, cnt SHALL increment every cycle, and the block SHALL take a sample on the edge where cnt==DWELL-1 (for DWELL=1, every edge).
REQ-021 At a sample, a sequence error SHALL be flagged when {x,y,z}!=idx.
REQ-022 At a sample, mism SHALL be set to {f4^EXP_F4[idx], f5^EXP_F5[idx], f6^EXP_F6[idx]}.
REQ-023 A sample SHALL be erroneous when the sequence error is set or mism!=0; an erroneous sample increments err_cnt by exactly 1.
REQ-024 On the first erroneous sample of a run, fail_valid SHALL be set to 1 and fail_idx to idx; later errors SHALL NOT change either output.
REQ-025 After a sample with idx<7, the block SHALL increment idx and clear cnt.
REQ-026 After a sample with idx==7, the block SHALL enter DONE, set done=1 and set pass=(resulting err_cnt==0), all on that same edge.
REQ-027 Timing: if start is taken at edge E0, vector k SHALL be sampled at E0+(k+1)*DWELL, and done SHALL rise at E0+8*DWELL.
REQ-028 busy SHALL equal (state==RUN), and all outputs SHALL be registered.
REQ-029 In DONE, all outputs SHALL hold until the next start or reset.
REQ-030 err_cnt SHALL never wrap, because its maximum value is 8.
REQ-031 Changes on x, y, z, f4, f5 or f6 between samples SHALL have no effect.

Reset
REQ-032 While rst_n==0, the block SHALL immediately enter IDLE regardless of clk, including mid-run.
REQ-033 While rst_n==0, cnt, idx, busy, done, pass, err_cnt, mism, fail_valid and fail_idx SHALL all be 0.
REQ-034 After rst_n rises, the block SHALL remain in IDLE until a start pulse.
REQ-035 A start pulse coincident with the rst_n release edge SHALL be ignored.

Verification
REQ-036 Correct DUT: DWELL=4, defaults, drive xyz 0..7 with 4-cycle holds and f per the tables -> done at E0+32, pass=1, err_cnt=0, fail_valid=0.
REQ-037 Single-output fault: force f6=1 at idx 3 -> mism=3'b001 after the 4th sample, fail_idx=3, err_cnt=1, pass=0.
REQ-038 Sequence fault: hold xyz at 2 through the idx-3 window -> err_cnt=1, fail_idx=3, mism=0 for that sample.
REQ-039 All bad: invert f4 every vector -> err_cnt=8, fail_idx=0, pass=0.
REQ-040 Mid-run reset and restart: assert rst_n=0 at cycle 10 of a run -> all outputs 0 asynchronously; new start -> clean run with done at E0+32.
REQ-041 Start during RUN: a second start pulse at cycle 5 -> ignored, done still at E0+32.
REQ-042 DWELL=1 run -> samples on 8 consecutive edges.
